// File: rtl/fmap_wr_packer.sv
// fmap_wr_packer: packs four strobed byte-pair lanes into 64-bit words, buffers them, and streams them with per-layer addresses.
module fmap_wr_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              layer,
  input  logic [3:0]              en_in,
  input  logic [DATA_WIDTH-1:0]   din0_b01,
  input  logic [DATA_WIDTH-1:0]   din1_b01,
  input  logic [DATA_WIDTH-1:0]   din0_b23,
  input  logic [DATA_WIDTH-1:0]   din1_b23,
  input  logic [DATA_WIDTH-1:0]   din0_b45,
  input  logic [DATA_WIDTH-1:0]   din1_b45,
  input  logic [DATA_WIDTH-1:0]   din0_b67,
  input  logic [DATA_WIDTH-1:0]   din1_b67,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*DATA_WIDTH-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err_ovf,
  output logic                    err_lane
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = 2 * DATA_WIDTH;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [3:0][LW-1:0] lane_q, lane_d, lane_in;
  logic [3:0] flag_q, flag_d;
  logic [ADDR_W-1:0] base_q, total_q, in_cnt_q, out_cnt_q, base_sel, tot_sel;
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic [8*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic err_ovf_q, err_lane_q, done_q, lerr;
  logic start_ok, push, pop, full, wr_en, accept, fin;
  assign lane_in = {{din1_b67, din0_b67}, {din1_b45, din0_b45}, {din1_b23, din0_b23}, {din1_b01, din0_b01}};
  assign base_sel = layer == 3'd1 ? ADDR_W'('h00000) : layer == 3'd2 ? ADDR_W'('h20000) :
                    layer == 3'd3 ? ADDR_W'('h28000) : ADDR_W'('h2A000);
  assign tot_sel  = layer == 3'd1 ? ADDR_W'(129600) : layer == 3'd2 ? ADDR_W'(32400) :
                    layer == 3'd3 ? ADDR_W'(8100) : ADDR_W'(2040);
  assign start_ok = start && state_q == IDLE && layer >= 3'd1 && layer <= 3'd4;
  assign push     = state_q == RUN && &flag_q;
  assign full     = cnt_q == CW'(FIFO_DEPTH);
  assign wr_en    = push && !full;
  assign pop      = wr_valid && wr_ready;
  // a strobe only counts while the word it would belong to is still within the layer
  assign accept   = state_q == RUN && (in_cnt_q + ADDR_W'(push)) < total_q;
  assign fin      = state_q == RUN && in_cnt_q == total_q && cnt_q == '0;
  always_comb begin
    flag_d = push ? 4'b0 : flag_q;
    lane_d = lane_q;
    lerr   = 1'b0;
    for (int i = 0; i < 4; i++)
      if (accept && en_in[i]) begin
        if (flag_d[i]) lerr = 1'b1;
        else begin
          flag_d[i] = 1'b1;
          lane_d[i] = lane_in[i];
        end
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = start_ok ? RUN : IDLE;
    else state_d = fin ? IDLE : RUN;
  end
  always_comb begin
    busy     = state_q == RUN;
    done     = done_q;
    err_ovf  = err_ovf_q;
    err_lane = err_lane_q;
    wr_valid = cnt_q != '0;
    wr_data  = wr_valid ? mem[rp_q] : '0;
    wr_addr  = base_q + out_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lane_q     <= '0;
      flag_q     <= '0;
      base_q     <= '0;
      total_q    <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      err_ovf_q  <= 1'b0;
      err_lane_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= fin;
      if (start_ok) begin
        base_q     <= base_sel;
        total_q    <= tot_sel;
        in_cnt_q   <= '0;
        out_cnt_q  <= '0;
        flag_q     <= '0;
        err_ovf_q  <= 1'b0;
        err_lane_q <= 1'b0;
      end else begin
        flag_q     <= flag_d;
        lane_q     <= lane_d;
        in_cnt_q   <= in_cnt_q + ADDR_W'(push);
        out_cnt_q  <= out_cnt_q + ADDR_W'(pop);
        err_ovf_q  <= err_ovf_q | (push && full);
        err_lane_q <= err_lane_q | lerr;
      end
      wp_q  <= wp_q + AW'(wr_en);
      rp_q  <= rp_q + AW'(pop);
      cnt_q <= cnt_q + CW'(wr_en) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wp_q] <= lane_q;
endmodule

// File: tb/tb_fmap_wr_packer.sv
// tb_fmap_wr_packer: randomized and directed checks of fmap_wr_packer against a queue-based reference model.
module tb_fmap_wr_packer;
  logic clk = 0, rst = 1, start = 0, wr_ready = 0;
  logic [2:0] layer = 0;
  logic [3:0] en_in = 0;
  logic [7:0] d0 [4], d1 [4];
  logic wr_valid, busy, done, err_ovf, err_lane;
  logic [19:0] wr_addr;
  logic [63:0] wr_data;
  fmap_wr_packer dut (
    .clk(clk), .rst(rst), .start(start), .layer(layer), .en_in(en_in),
    .din0_b01(d0[0]), .din1_b01(d1[0]), .din0_b23(d0[1]), .din1_b23(d1[1]),
    .din0_b45(d0[2]), .din1_b45(d1[2]), .din0_b67(d0[3]), .din1_b67(d1[3]),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_ovf(err_ovf), .err_lane(err_lane));
  always #5 clk = ~clk;
  int total_n = 0, bad_n = 0, hs = 0, dn = 0;
  logic [19:0] last_addr = 0;
  bit rnd = 1;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      if (bad_n < 40) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction
  // reference model: layer table, per-lane flags, and a plain queue for the word buffer
  logic [19:0] tb_base [1:4] = '{20'h00000, 20'h20000, 20'h28000, 20'h2A000};
  logic [19:0] tb_tot [1:4] = '{20'd129600, 20'd32400, 20'd8100, 20'd2040};
  bit m_run, m_ovf, m_lerr, m_done;
  bit [3:0] m_flag;
  logic [15:0] m_lane [4];
  logic [19:0] m_base, m_tot, m_in, m_out;
  logic [63:0] mq [$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_ovf = 0; m_lerr = 0; m_done = 0; m_flag = 0;
      m_base = 0; m_tot = 0; m_in = 0; m_out = 0; mq.delete();
    end else begin
      automatic bit pop = mq.size() != 0 && wr_ready;
      automatic bit push = m_run && (&m_flag);
      automatic bit fin = m_run && m_in == m_tot && mq.size() == 0;
      automatic bit full = mq.size() == 16;
      automatic logic [63:0] w = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
      automatic bit acc = m_run && (m_in + 20'(push)) < m_tot;
      m_done = fin;
      if (!m_run && start && layer >= 1 && layer <= 4) begin
        m_run = 1; m_base = tb_base[layer]; m_tot = tb_tot[layer];
        m_in = 0; m_out = 0; m_ovf = 0; m_lerr = 0; m_flag = 0;
      end else begin
        if (pop) begin void'(mq.pop_front()); m_out++; end
        if (push) begin
          if (full) m_ovf = 1; else mq.push_back(w);
          m_in++; m_flag = 0;
        end
        for (int i = 0; i < 4; i++)
          if (acc && en_in[i]) begin
            if (m_flag[i]) m_lerr = 1;
            else begin m_flag[i] = 1; m_lane[i] = {d1[i], d0[i]}; end
          end
        if (fin) m_run = 0;
      end
    end
  end
  always @(negedge clk) begin
    chk("valid", 64'(wr_valid), 64'(mq.size() != 0));
    chk("busy", 64'(busy), 64'(m_run));
    chk("done", 64'(done), 64'(m_done));
    chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
    chk("err_lane", 64'(err_lane), 64'(m_lerr));
    if (mq.size() != 0) begin
      chk("data", wr_data, mq[0]);
      chk("addr", 64'(wr_addr), 64'(m_base + m_out));
    end
    if (wr_valid && wr_ready) begin hs++; last_addr = wr_addr; end
    if (done) dn++;
  end
  task automatic step(input logic [3:0] en, input logic rdy, input logic st = 0, input logic [2:0] ly = 0);
    en_in = en; wr_ready = rdy; start = st; layer = ly;
    if (rnd) for (int i = 0; i < 4; i++) begin d0[i] = 8'($urandom); d1[i] = 8'($urandom); end
    @(posedge clk); #1;
    en_in = 0; start = 0;
  endtask
  task automatic do_reset();
    wr_ready = 0; rst = 1; #1;
    @(negedge clk); rst = 0;
  endtask
  initial begin
    int h0, n0;
    bit got;
    for (int i = 0; i < 4; i++) begin d0[i] = 0; d1[i] = 0; end
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(wr_valid), 0); chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0); chk("rst_addr", 64'(wr_addr), 0);
    chk("rst_data", wr_data, 0); chk("rst_errs", 64'({err_ovf, err_lane}), 0);
    rst = 0;
    step(0, 0, 1, 6);
    chk("bad_layer_busy", 64'(busy), 0);
    // staggered lanes, fixed bytes
    step(0, 0, 1, 3);
    chk("l3_busy", 64'(busy), 1);
    rnd = 0;
    d0[0] = 8'h11; d1[0] = 8'h22; d0[1] = 8'h33; d1[1] = 8'h44;
    d0[2] = 8'h55; d1[2] = 8'h66; d0[3] = 8'h77; d1[3] = 8'h88;
    step(1, 0); step(2, 0); step(4, 0); step(8, 0);
    chk("stag_not_yet", 64'(wr_valid), 0);
    step(0, 0);
    chk("stag_valid", 64'(wr_valid), 1);
    chk("stag_data", wr_data, 64'h8877665544332211);
    chk("stag_addr", 64'(wr_addr), 64'h28000);
    // repeated b01 strobe keeps the first bytes
    d0[0] = 8'hA1; d1[0] = 8'hA2; step(1, 0);
    d0[0] = 8'hB1; d1[0] = 8'hB2; step(1, 0);
    chk("lane_err", 64'(err_lane), 1);
    step(4'he, 0); step(0, 0);
    step(0, 1);
    wr_ready = 0;
    chk("lane_word_lo", 64'(wr_data[15:0]), 64'hA2A1);
    chk("lane_word_addr", 64'(wr_addr), 64'h28001);
    chk("pre_rst_valid", 64'(wr_valid), 1);
    rst = 1; #1;
    chk("mid_rst_valid", 64'(wr_valid), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    @(negedge clk); rst = 0;
    rnd = 1;
    step(0, 0, 1, 3); step(4'hf, 0);
    chk("restart_empty", 64'(wr_valid), 0);
    step(0, 0);
    chk("restart_addr", 64'(wr_addr), 64'h28000);
    step(4'hf, 0, 1, 1); step(0, 0);
    chk("start_in_run_addr", 64'(wr_addr), 64'h28000);
    do_reset();
    // overflow: 17 words into a 16-deep buffer with no ready
    step(0, 0, 1, 2);
    repeat (17) step(4'hf, 0);
    step(0, 0);
    chk("ovf_flag", 64'(err_ovf), 1);
    h0 = hs;
    for (int k = 0; k < 40 && wr_valid; k++) step(0, 1);
    chk("ovf_drain_writes", 64'(hs - h0), 16);
    chk("ovf_last_addr", 64'(last_addr), 64'h2000F);
    do_reset();
    // full layer 4, every lane every cycle, always ready
    step(0, 1, 1, 4);
    h0 = hs; n0 = dn;
    repeat (2040) step(4'hf, 1);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin step(0, 1); got = done; end
    step(0, 1); step(0, 1);
    chk("l4_done_seen", 64'(got), 1);
    chk("l4_writes", 64'(hs - h0), 2040);
    chk("l4_done_once", 64'(dn - n0), 1);
    chk("l4_last_addr", 64'(last_addr), 64'h2A7F7);
    chk("l4_errs", 64'({err_ovf, err_lane}), 0);
    chk("l4_idle", 64'(busy), 0);
    // random strobes and backpressure, with stray starts mid-layer
    step(0, 1, 1, 4);
    got = 0;
    for (int k = 0; k < 40000 && !got; k++) begin
      step(4'($urandom), ($urandom % 4) != 0, ($urandom % 200) == 0, 3'($urandom_range(1, 4)));
      got = done;
    end
    chk("rand_done_seen", 64'(got), 1);
    step(0, 1); step(0, 1);
    chk("rand_idle", 64'(busy), 0);
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule
